// File: rtl/button_press_classifier.sv
// button_press_classifier
//   Classifies a debounced push-button into short press, long press and
//   double click events, plus a level that stays high while a long press
//   is still being held.
//
// Parameters
//   LONG_PRESS_CYCLES  hold time (cycles) that qualifies a long press, >= 2
//   DOUBLE_GAP_CYCLES  max release-to-repress gap (cycles) for a double, >= 2
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_debounced  clean button level, 1 = pressed
//   o_short      one-cycle pulse: single short press completed
//   o_long       one-cycle pulse: press held for LONG_PRESS_CYCLES
//   o_double     one-cycle pulse: second press released inside the gap
//   o_held       level: a qualified long press is still held
module button_press_classifier #(
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 25_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_debounced,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_held
);

    localparam int unsigned MAX_CYCLES =
        (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HELD
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic          d_q;
    logic          short_nxt;
    logic          long_nxt;
    logic          double_nxt;
    logic          held_nxt;

    // State register, cycle counter, input delay and registered outputs.
    // d_q resets to 1 so a button held through reset is not seen as a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            count    <= '0;
            d_q      <= 1'b1;
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
            o_held   <= 1'b0;
        end else begin
            state    <= next_state;
            d_q      <= i_debounced;
            if (next_state != state) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
            o_short  <= short_nxt;
            o_long   <= long_nxt;
            o_double <= double_nxt;
            o_held   <= held_nxt;
        end
    end

    // Next-state logic. Input level is tested before the counter limit so a
    // release/press coinciding with the limit edge takes priority.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (i_debounced && !d_q) begin
                    next_state = PRESS1;
                end
            end
            PRESS1: begin
                if (!i_debounced) begin
                    next_state = WAIT_GAP;
                end else if (count == LONG_LAST) begin
                    next_state = LONG_HELD;
                end
            end
            WAIT_GAP: begin
                if (i_debounced) begin
                    next_state = PRESS2;
                end else if (count == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            PRESS2: begin
                if (!i_debounced) begin
                    next_state = IDLE;
                end
            end
            LONG_HELD: begin
                if (!i_debounced) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the transition being taken; registered above.
    always_comb begin
        short_nxt  = (state == WAIT_GAP) && (next_state == IDLE);
        long_nxt   = (state == PRESS1)   && (next_state == LONG_HELD);
        double_nxt = (state == PRESS2)   && (next_state == IDLE);
        held_nxt   = (next_state == LONG_HELD);
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb_button_press_classifier
//   Self-checking bench for button_press_classifier (LONG=20, GAP=10).
//   Expected outputs per cycle are derived from gesture run lengths
//   (press length, gap length, second press length) with plain arithmetic.
module tb_button_press_classifier;

    localparam int L = 20;
    localparam int G = 10;

    logic i_clk;
    logic i_rst_n;
    logic i_debounced;
    logic o_short;
    logic o_long;
    logic o_double;
    logic o_held;

    int n_cmp;
    int n_fail;
    int cyc;

    button_press_classifier #(
        .LONG_PRESS_CYCLES(L),
        .DOUBLE_GAP_CYCLES(G)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_debounced(i_debounced),
        .o_short    (o_short),
        .o_long     (o_long),
        .o_double   (o_double),
        .o_held     (o_held)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input logic es, input logic el, input logic ed, input logic eh);
        check("short",  o_short,  es);
        check("long",   o_long,   el);
        check("double", o_double, ed);
        check("held",   o_held,   eh);
    endtask

    // One clock: drive the level sampled at the next edge, then check the
    // outputs registered by that edge.
    task automatic step(input logic din, input logic es, input logic el,
                        input logic ed, input logic eh);
        i_debounced = din;
        @(posedge i_clk);
        #1;
        cyc++;
        check_all(es, el, ed, eh);
    endtask

    // A gesture: idle zeros, a press of p cycles, then either a long press
    // (p > L), a short (gap g > G) or a double (gap g <= G, second press q).
    task automatic gesture(input int idle, input int p, input int g, input int q);
        int  t0, t1, t2, len;
        bit  is_long, is_short, is_double;
        bit  din, es, el, ed, eh;
        t0        = idle;
        t1        = t0 + p;
        t2        = t1 + g;
        is_long   = (p >= L + 1);
        is_short  = !is_long && (g >= G + 1);
        is_double = !is_long && !is_short;
        if (is_long)       len = t1;
        else if (is_short) len = t1 + g;
        else               len = t2 + q + 1;
        for (int i = 0; i < len; i++) begin
            din = (i >= t0 && i < t1) || (is_double && i >= t2 && i < t2 + q);
            es  = is_short  && (i == t1 + G);
            el  = is_long   && (i == t0 + L);
            eh  = is_long   && (i >= t0 + L) && (i < t1);
            ed  = is_double && (i == t2 + q);
            step(din, es, el, ed, eh);
        end
    endtask

    task automatic quiet(input logic din, input int n);
        for (int i = 0; i < n; i++) step(din, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Async reset pulse from mid-cycle; outputs must clear before any edge.
    task automatic async_reset(input logic din);
        i_debounced = din;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk);
            #1;
            check_all(1'b0, 1'b0, 1'b0, 1'b0);
        end
        i_rst_n = 1'b1;
    endtask

    initial begin
        int idle, p, g, q, sel;
        n_cmp       = 0;
        n_fail      = 0;
        cyc         = 0;
        i_rst_n     = 1'b0;
        i_debounced = 1'b1;

        // Reset with the button held throughout.
        repeat (3) @(posedge i_clk);
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;

        // Held across reset release: nothing may be classified.
        quiet(1'b1, 40);

        // Drop then re-press: normal short press.
        gesture(2, 5, 15, 0);
        // Long press held 30 cycles.
        gesture(3, 30, 0, 0);
        // Double click: press 4, release 6, press 3.
        gesture(3, 4, 6, 3);
        // Release exactly on the limit edge: short, not long.
        gesture(3, L, 15, 0);
        // One cycle longer: long press.
        gesture(3, L + 1, 0, 0);
        // Re-press exactly on the gap limit edge: double.
        gesture(3, 5, G, 3);
        // Gap one cycle longer: short.
        gesture(3, 5, G + 1, 0);
        // Very long second press never yields o_long.
        gesture(3, 2, 1, 40);

        // Reset during WAIT_GAP: no short may ever appear.
        quiet(1'b0, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(1'b1, 4);
        quiet(1'b0, 4);
        async_reset(1'b0);
        quiet(1'b0, 20);

        // Reset during LONG_HELD: o_held must drop at once; still held after.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(1'b1, L - 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        async_reset(1'b1);
        quiet(1'b1, 30);
        gesture(2, 6, 12, 0);

        // Randomized gestures with boundary values mixed in.
        for (int n = 0; n < 60; n++) begin
            idle = int'($urandom_range(1, 5));
            sel  = int'($urandom_range(0, 3));
            if (sel == 0)      p = L;
            else if (sel == 1) p = L + 1;
            else               p = int'($urandom_range(1, L + 8));
            sel  = int'($urandom_range(0, 3));
            if (sel == 0)      g = G;
            else if (sel == 1) g = G + 1;
            else               g = int'($urandom_range(1, G + 6));
            q    = int'($urandom_range(1, 30));
            gesture(idle, p, g, q);
        end
        quiet(1'b0, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter LONG_PRESS_CYCLES, default 50_000_000, is the hold time in clock cycles (500 ms at 100 MHz) that qualifies a long press; legal values >= 2.
REQ-002 Parameter DOUBLE_GAP_CYCLES, default 25_000_000, is the maximum release-to-repress gap in cycles (250 ms at 100 MHz) for a double click; legal values >= 2.
REQ-003 i_clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_debounced  input  1  clean button level from the upstream debouncer, synchronous to i_clk; 1 = pressed.
REQ-006 o_short  output  1  one-cycle pulse: single short press and release completed.
REQ-007 o_long  output  1  one-cycle pulse: press held for LONG_PRESS_CYCLES.
REQ-008 o_double  output  1  one-cycle pulse: second press released within the gap window.
REQ-009 o_held  output  1  level, high while a qualified long press is still held.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 Each pulse SHALL be high for exactly the one cycle following the clock edge that detects its event.
REQ-012 A delayed copy d_q of i_debounced SHALL be kept; a press is an edge sampling i_debounced=1 with d_q=0, and a release is an edge sampling i_debounced=0.
REQ-013 Cycle counter width SHALL be $clog2(max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES)+1) bits; the counter SHALL clear on every state change and increment by 1 per cycle otherwise.
REQ-014 The FSM SHALL have the states IDLE, PRESS1, WAIT_GAP, PRESS2 and LONG_HELD.
REQ-015 IDLE: on a press edge, go to PRESS1; no other event changes state.
REQ-016 PRESS1, release sampled: go to WAIT_GAP with no pulse.
REQ-017 PRESS1, i_debounced sampled 1 on the edge where the counter = LONG_PRESS_CYCLES-1: assert o_long and go to LONG_HELD.
REQ-018 LONG_HELD: o_held=1; on release, go to IDLE with o_held dropping the following cycle; no o_short is emitted.
REQ-019 WAIT_GAP, i_debounced sampled 1: go to PRESS2.
REQ-020 WAIT_GAP, i_debounced sampled 0 on the edge where the counter = DOUBLE_GAP_CYCLES-1: assert o_short and go to IDLE.
REQ-021 PRESS2: on release, of any duration, assert o_double and go to IDLE; the counter is unused in this state, and o_long is never asserted from PRESS2.
REQ-022 Simultaneous events:
- Release on the edge where PRESS1 reaches its limit: treat as release, go to WAIT_GAP, no o_long.
- Press on the edge where WAIT_GAP reaches its limit: treat as press, go to PRESS2, no o_short.
REQ-023 At most one of o_short, o_long and o_double SHALL be high in any cycle.
REQ-024 Latency, with t0 = the press edge:
- o_long is high in the cycle after edge t0+LONG_PRESS_CYCLES.
- o_short is high in the cycle after edge t1+DOUBLE_GAP_CYCLES, where t1 is the release edge.

Reset
REQ-025 While i_rst_n=0, regardless of the clock: state = IDLE, counter = 0, o_short = o_long = o_double = o_held = 0, d_q = 1.
REQ-026 Because d_q resets to 1, a button held across reset release SHALL NOT be classified until it is released and pressed again.
REQ-027 Reset asserted mid-sequence (any state) SHALL abort the sequence with no pulse emitted.
REQ-028 Deassertion of i_rst_n is synchronised by the system; the block takes no further action on it.

Verification (LONG_PRESS_CYCLES=20, DOUBLE_GAP_CYCLES=10, 10 ns clock)
REQ-029 Reset check: i_debounced=1 throughout reset, release reset, hold 40 cycles -> no pulse, o_held=0.
- Then drop the input and raise it again -> classified normally.
REQ-030 Short press: press 5 cycles, release -> o_short high for exactly one cycle, 10 cycles after the release edge; o_long and o_double stay 0.
REQ-031 Long press: hold 30 cycles -> o_long pulses in the cycle after press edge+20.
- o_held is high from that cycle until one cycle after release.
- No o_short follows.
REQ-032 Double click: press 4, release 6, press 3, release -> o_double pulses one cycle after the second release; no o_short, no o_long.
REQ-033 Boundaries:
- Release exactly on the 20th edge -> no o_long; o_short follows 10 cycles later.
- Re-press exactly on the 10th gap edge -> PRESS2; o_double follows on release.
REQ-034 Mid-sequence reset: assert i_rst_n=0 during WAIT_GAP -> no o_short ever appears; all outputs are 0 immediately.
